// File: rtl/exmem_skid_stage.sv
// EX/MEM elastic pipeline stage with a two-entry skid buffer; state advances on the falling clock edge.
// Define EXMEM_SKID_STATS_EN to add the saturating stall/flush counters.
module exmem_skid_stage #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wipe,
  input  logic              power,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_control,
  input  logic [XLEN-1:0]   in_pcp,
  input  logic [XLEN-1:0]   in_alu,
  input  logic [XLEN-1:0]   in_r2,
  input  logic [REG_AW-1:0] in_wr,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_control,
  output logic [XLEN-1:0]   out_pcp,
  output logic [XLEN-1:0]   out_alu,
  output logic [XLEN-1:0]   out_r2,
  output logic [REG_AW-1:0] out_wr,
  output logic              out_zero
`ifdef EXMEM_SKID_STATS_EN
  ,
  output logic [15:0]       stat_stall_cnt,
  output logic [15:0]       stat_flush_cnt
`endif
);

  localparam int unsigned PW = CTRL_W + 3 * XLEN + REG_AW + 1;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_e;

  occ_e          occ_q, occ_d;
  logic [PW-1:0] m_q, m_d;
  logic [PW-1:0] s_q, s_d;
  logic [PW-1:0] in_pl;
  logic          push, pop;

  assign in_pl = {in_control, in_pcp, in_alu, in_r2, in_wr, in_zero};
  assign {out_control, out_pcp, out_alu, out_r2, out_wr, out_zero} = m_q;

  // Occupancy state register.
  always_ff @(negedge clk) begin
    if (reset) occ_q <= EMPTY;
    else       occ_q <= occ_d;
  end

  // Entry registers; an empty entry always holds zeros so bubbles carry no writes.
  always_ff @(negedge clk) begin
    if (reset) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      m_q <= m_d;
      s_q <= s_d;
    end
  end

  // Next occupancy and entry contents.
  always_comb begin
    occ_d = occ_q;
    m_d   = m_q;
    s_d   = s_q;
    if (reset || wipe) begin
      occ_d = EMPTY;
      m_d   = '0;
      s_d   = '0;
    end else if (power) begin
      unique case (occ_q)
        EMPTY: begin
          if (push) begin
            occ_d = ONE;
            m_d   = in_pl;
          end
        end
        ONE: begin
          if (push && pop) begin
            m_d = in_pl;
          end else if (push) begin
            occ_d = TWO;
            s_d   = in_pl;
          end else if (pop) begin
            occ_d = EMPTY;
            m_d   = '0;
          end
        end
        TWO: begin
          if (pop) begin
            occ_d = ONE;
            m_d   = s_q;
            s_d   = '0;
          end
        end
        default: begin
          occ_d = EMPTY;
          m_d   = '0;
          s_d   = '0;
        end
      endcase
    end
  end

  // Handshakes depend only on occupancy, power and reset, never on out_ready.
  always_comb begin
    in_ready  = power & ~reset & (occ_q != TWO);
    out_valid = power & ~reset & (occ_q != EMPTY);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

`ifdef EXMEM_SKID_STATS_EN
  logic [15:0] stall_q, flush_q;

  // Saturating counters; only reset clears them.
  always_ff @(negedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (power && out_valid && !out_ready && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
      if (wipe && occ_q != EMPTY && flush_q != 16'hFFFF)
        flush_q <= flush_q + 16'd1;
    end
  end

  assign stat_stall_cnt = stall_q;
  assign stat_flush_cnt = flush_q;
`endif

endmodule
